// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial link: the receiver state encoding, the
// default word width and the even-parity helper also used by the transmitter.
// -----------------------------------------------------------------------------
package serial_pkg;

  // Receiver frame states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DRAIN  = 2'd3
  } rx_state_e;

  localparam int SERIAL_WIDTH_DEFAULT = 32;

  // Even parity bit for a word: the bit that makes the total count of ones
  // even. Callers zero-extend narrower words to 64 bits.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/serial_rx_holdreg.sv
// -----------------------------------------------------------------------------
// serial_rx_holdreg
// One-entry holding register between the deserialiser and the consumer.
// A completed word is accepted when the register is empty or is being acked in
// the same cycle; otherwise it is dropped and an overrun pulse is raised.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   load         : a completed word is offered this cycle
//   load_data    : the completed word
//   ack          : consumer accepts the current word
//   data_out     : held word (keeps its value until replaced)
//   valid        : register full
//   done         : one-cycle pulse, word accepted
//   overrun      : one-cycle pulse, word dropped
//   accept       : combinational, the offered word is taken this cycle
// -----------------------------------------------------------------------------
module serial_rx_holdreg
  import serial_pkg::*;
#(
  parameter int width = SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             ack,
  output logic [width-1:0] data_out,
  output logic             valid,
  output logic             done,
  output logic             overrun,
  output logic             accept
);

  logic [width-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             accept_s;

  // Load / ack / overrun decision; ack has priority so back-to-back words
  // never overrun when the consumer keeps up.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    accept_s  = load & (~valid_q | ack);
    if (accept_s) begin
      data_d  = load_data;
      valid_d = 1'b1;
      done_d  = 1'b1;
    end else if (load) begin
      overrun_d = 1'b1;
    end else if (ack) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register state and pulse flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign done     = done_q;
  assign overrun  = overrun_q;
  assign accept   = accept_s;

endmodule

// File: rtl/serial_receiver.sv
// -----------------------------------------------------------------------------
// serial_receiver
// Deserialises an MSB-first bit stream framed by rxEn into a width-bit word and
// hands it to the consumer through a one-entry holding register.
//
// Optional feature: define SERIAL_RX_PARITY_EN to expect one extra even-parity
// bit after the data; without it the frame is width bits and parityErr is 0.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   din        : serial data, MSB first, one bit per clk while rxEn=1
//   rxEn       : frame enable, high for the bits of one frame
//   dataAck    : consumer accepts dataOut
//   dataOut    : last completed word
//   dataValid  : holding register full
//   rxBusy     : frame reception in progress
//   rxDone     : pulse, good frame completed and loaded
//   overrun    : pulse, completed word dropped (register still full)
//   frameErr   : pulse, rxEn fell mid-frame
//   parityErr  : pulse with rxDone when the parity bit mismatches
// -----------------------------------------------------------------------------
module serial_receiver
  import serial_pkg::*;
#(
  parameter int width = SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             rxEn,
  input  logic             dataAck,
  output logic [width-1:0] dataOut,
  output logic             dataValid,
  output logic             rxBusy,
  output logic             rxDone,
  output logic             overrun,
  output logic             frameErr,
  output logic             parityErr
);

  localparam int CNT_W = $clog2(width + 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [width-1:0] shreg_q, shreg_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             rx_busy_q, rx_busy_d;

  logic             complete_s;
  logic [width-1:0] complete_word_s;
  logic             parity_bad_s;
  logic             accept_s;

  // Frame FSM: bit capture, completion and abort detection.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    shreg_d         = shreg_q;
    frame_err_d     = 1'b0;
    complete_s      = 1'b0;
    complete_word_s = shreg_q;
    parity_bad_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxEn) begin
          // First bit arrives in the same cycle rxEn rises. Shifting left
          // each later cycle walks it up to bit width-1 by frame end.
          shreg_d = {{(width-1){1'b0}}, din};
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end else begin
          cnt_d   = CNT_W'(0);
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (rxEn) begin
          shreg_d = {shreg_q[width-2:0], din};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(width - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            complete_s      = 1'b1;
            complete_word_s = {shreg_q[width-2:0], din};
            state_d         = DRAIN;
`endif
          end else begin
            state_d = SHIFT;
          end
        end else begin
          frame_err_d = 1'b1;
          shreg_d     = '0;
          cnt_d       = CNT_W'(0);
          state_d     = IDLE;
        end
      end
      PARITY: begin
`ifdef SERIAL_RX_PARITY_EN
        if (rxEn) begin
          complete_s      = 1'b1;
          complete_word_s = shreg_q;
          parity_bad_s    = even_parity({{(64-width){1'b0}}, shreg_q}) ^ din;
          state_d         = DRAIN;
        end else begin
          frame_err_d = 1'b1;
          shreg_d     = '0;
          cnt_d       = CNT_W'(0);
          state_d     = IDLE;
        end
`else
        // Unreachable without the parity feature; recover to IDLE.
        cnt_d   = CNT_W'(0);
        state_d = IDLE;
`endif
      end
      DRAIN: begin
        // Bits beyond the frame are dropped until the link goes quiet.
        if (!rxEn) begin
          cnt_d   = CNT_W'(0);
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        cnt_d   = CNT_W'(0);
        shreg_d = '0;
        state_d = IDLE;
      end
    endcase
    rx_busy_d = (state_d == SHIFT) || (state_d == PARITY);
    // A parity error is only reported for a word that is actually loaded.
    parity_err_d = parity_bad_s & accept_s;
  end

  // FSM state, counter, shift register and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      rx_busy_q    <= rx_busy_d;
    end
  end

  serial_rx_holdreg #(
    .width(width)
  ) u_holdreg (
    .clk      (clk),
    .reset    (reset),
    .load     (complete_s),
    .load_data(complete_word_s),
    .ack      (dataAck),
    .data_out (dataOut),
    .valid    (dataValid),
    .done     (rxDone),
    .overrun  (overrun),
    .accept   (accept_s)
  );

  assign rxBusy    = rx_busy_q;
  assign frameErr  = frame_err_q;
  assign parityErr = parity_err_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: the driver predicts each frame's
// outcome with a simple word-level model and queues it; the monitor pops and
// compares whenever the DUT raises one of its status pulses.
module tb_serial_receiver;

  localparam int W = 32;
`ifdef SERIAL_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         din = 1'b0;
  logic         rxEn = 1'b0;
  logic         dataAck = 1'b0;
  logic [W-1:0] dataOut;
  logic         dataValid, rxBusy, rxDone, overrun, frameErr, parityErr;

  always #5 clk = ~clk;

  serial_receiver #(.width(W)) dut (
    .clk(clk), .reset(reset), .din(din), .rxEn(rxEn), .dataAck(dataAck),
    .dataOut(dataOut), .dataValid(dataValid), .rxBusy(rxBusy), .rxDone(rxDone),
    .overrun(overrun), .frameErr(frameErr), .parityErr(parityErr)
  );

  typedef struct {
    logic         done;
    logic         ovr;
    logic         ferr;
    logic         perr;
    logic [W-1:0] data;
    logic         valid;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Word-level model of the holding register.
  logic [W-1:0] m_data = '0;
  logic         m_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic d, input logic o, input logic f, input logic p,
                      input logic [W-1:0] data, input logic valid);
    exp_t e;
    e.done = d; e.ovr = o; e.ferr = f; e.perr = p; e.data = data; e.valid = valid;
    sb.push_back(e);
  endtask

  // One clock: drive inputs, let the edge pass, compare visible state.
  task automatic step(input logic b, input logic e, input logic a, input logic exp_busy);
    din = b; rxEn = e; dataAck = a;
    @(posedge clk);
    #1;
    chk("dataValid", 64'(dataValid), 64'(m_valid));
    chk("dataOut", 64'(dataOut), 64'(m_data));
    chk("rxBusy", 64'(rxBusy), 64'(exp_busy));
  endtask

  task automatic idle(input int n, input bit rand_ack);
    for (int i = 0; i < n; i++) begin
      logic a;
      a = rand_ack ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (a) m_valid = 1'b0;
      step(1'b0, 1'b0, a, 1'b0);
    end
  endtask

  // Expected outcome of a completed frame.
  task automatic complete(input logic [W-1:0] w, input logic bad, input logic ack);
    if (!m_valid || ack) begin
      m_data  = w;
      m_valid = 1'b1;
      push(1'b1, 1'b0, 1'b0, bad, w, 1'b1);
    end else begin
      push(1'b0, 1'b1, 1'b0, 1'b0, m_data, 1'b1);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic pbit, input logic ack,
                            input int extra);
    for (int i = 0; i < W + P; i++) begin
      logic b;
      bit   last;
      last = (i == W + P - 1);
      b = (i < W) ? w[W-1-i] : pbit;
      if (last) complete(w, (P == 1) && (pbit != ^w), ack);
      step(b, 1'b1, last ? ack : 1'b0, !last);
    end
    for (int i = 0; i < extra; i++) step($urandom_range(0, 1) == 1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic abort_frame(input logic [W-1:0] w, input int k);
    for (int i = 0; i < k; i++) step((i < W) ? w[W-1-i] : 1'b0, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b1, 1'b0, m_data, m_valid);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every status pulse must match the oldest predicted outcome.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && (rxDone || overrun || frameErr || parityErr)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%0b ovr=%0b ferr=%0b perr=%0b expected none at %0t",
                 rxDone, overrun, frameErr, parityErr, $time);
      end else begin
        e = sb.pop_front();
        chk("rxDone_pulse", 64'(rxDone), 64'(e.done));
        chk("overrun_pulse", 64'(overrun), 64'(e.ovr));
        chk("frameErr_pulse", 64'(frameErr), 64'(e.ferr));
        chk("parityErr_pulse", 64'(parityErr), 64'(e.perr));
        chk("event_dataOut", 64'(dataOut), 64'(e.data));
        chk("event_dataValid", 64'(dataValid), 64'(e.valid));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_dataOut"}, 64'(dataOut), 64'd0);
    chk({tag, "_dataValid"}, 64'(dataValid), 64'd0);
    chk({tag, "_rxBusy"}, 64'(rxBusy), 64'd0);
    chk({tag, "_rxDone"}, 64'(rxDone), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    chk({tag, "_frameErr"}, 64'(frameErr), 64'd0);
    chk({tag, "_parityErr"}, 64'(parityErr), 64'd0);
  endtask

  initial begin : driver
    logic [W-1:0] w;
    logic         pb;
    #1 reset = 1'b1;
    #1 check_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Single word from empty register.
    send_frame(32'hA5A5_1234, ~(^32'hA5A5_1234), 1'b0, 0);
    chk("first_word", 64'(dataOut), 64'h0000_0000_A5A5_1234);
    idle(1, 1'b0);
    dataAck = 1'b1; m_valid = 1'b0; step(1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back without ack: second word overruns.
    send_frame(32'h0000_0001, 1'b1, 1'b0, 0);
    idle(1, 1'b0);
    send_frame(32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    chk("overrun_keeps_word", 64'(dataOut), 64'h1);
    idle(1, 1'b0);
    m_valid = 1'b0; step(1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back with ack on the second completion edge.
    send_frame(32'h0000_0001, 1'b1, 1'b0, 0);
    idle(1, 1'b0);
    send_frame(32'hFFFF_FFFF, 1'b0, 1'b1, 1);
    chk("ack_replaces_word", 64'(dataOut), 64'hFFFF_FFFF);
    idle(2, 1'b0);

    // Abort after 10 bits, then a clean frame.
    abort_frame(32'h1357_9BDF, 10);
    send_frame(32'h2468_ACE0, ^32'h2468_ACE0, 1'b1, 0);
    idle(1, 1'b0);

    // Reset in the middle of a frame.
    w = 32'hDEAD_BEEF;
    for (int i = 0; i < 16; i++) step(w[W-1-i], 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    #1 check_all_zero("midframe_reset");
    m_valid = 1'b0; m_data = '0;
    rxEn = 1'b0; din = 1'b0; dataAck = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    send_frame(32'hC0FF_EE11, ^32'hC0FF_EE11, 1'b0, 0);
    idle(1, 1'b0);

`ifdef SERIAL_RX_PARITY_EN
    // Parity mismatch then match on 0x3 (correct even parity bit is 0).
    send_frame(32'h0000_0003, 1'b1, 1'b1, 0);
    idle(1, 1'b0);
    send_frame(32'h0000_0003, 1'b0, 1'b1, 0);
    idle(1, 1'b0);
`endif

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      if ($urandom_range(0, 6) == 0) begin
        abort_frame(w, int'($urandom_range(1, W + P - 1)));
        idle(int'($urandom_range(0, 2)), 1'b1);
      end else begin
        pb = (^w) ^ ($urandom_range(0, 3) == 0);
        send_frame(w, pb, $urandom_range(0, 1) == 1, int'($urandom_range(0, 2)));
        idle(int'($urandom_range(1, 3)), 1'b1);
      end
    end

    idle(3, 1'b0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
